// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result capture path.
// No logic or state of its own.
package alu_pkg;

    localparam int ALU_W = 5;

    typedef struct packed {
        logic             zf;
        logic [ALU_W-1:0] r;
    } alu_res_t;

    // Increment that holds at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/alu_res_mem.sv
// DEPTH-entry register file of ALU results; write lands on the next edge, read is combinational.
// No backpressure: the caller decides when a write is allowed.
module alu_res_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_waddr,
    input  logic [$bits(alu_res_t)-1:0]  i_wdat,
    input  logic [AW-1:0]                i_raddr,
    output logic [$bits(alu_res_t)-1:0]  o_rdat
);

    logic [$bits(alu_res_t)-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Buffers ALU results (R, ZF) and keeps push statistics; a push is visible one cycle later.
// in_ready drops only when full (no pop bypass); a push while full is discarded and sets sticky drop.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [W-1:0]             R,
    input  logic                     ZF,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_r,
    output logic                     out_zf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         res_cnt,
    output logic [CNT_W-1:0]         zero_cnt,
    output logic [CNT_W-1:0]         r_sum,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_res_cnt;
    logic [CNT_W-1:0] r_zero_cnt;
    logic [CNT_W-1:0] r_sum_acc;
    logic             r_drop;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_max;
    alu_res_t         w_wr_ent;
    alu_res_t         w_head;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;
    assign w_cnt_max = '1;

    always_comb begin
        w_wr_ent    = '0;
        w_wr_ent.zf = ZF;
        w_wr_ent.r  = R;
    end

    alu_res_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdat  (w_wr_ent),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdat  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_cnt  <= '0;
            r_zero_cnt <= '0;
            r_sum_acc  <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_push) begin
                r_res_cnt <= CNT_W'(sat_inc(32'(r_res_cnt), 32'(w_cnt_max)));
                if (ZF) begin
                    r_zero_cnt <= CNT_W'(sat_inc(32'(r_zero_cnt), 32'(w_cnt_max)));
                end
                r_sum_acc <= r_sum_acc + CNT_W'(R);
            end
            if (in_valid && w_full) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_r     = w_head.r;
    assign out_zf    = w_head.zf;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign res_cnt   = r_res_cnt;
    assign zero_cnt  = r_zero_cnt;
    assign r_sum     = r_sum_acc;
    assign drop      = r_drop;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: queue-based reference model, a table of fill/overflow/drain vectors,
// directed corner sequences and randomized traffic.
module tb_alu_result_fifo;

    localparam int W     = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     R;
    logic             ZF;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_r;
    logic             out_zf;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] res_cnt;
    logic [CNT_W-1:0] zero_cnt;
    logic [CNT_W-1:0] r_sum;
    logic             drop;

    always #5 clk = ~clk;

    alu_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .R         (R),
        .ZF        (ZF),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_zf    (out_zf),
        .level     (level),
        .res_cnt   (res_cnt),
        .zero_cnt  (zero_cnt),
        .r_sum     (r_sum),
        .drop      (drop)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a plain queue of {zf, r} plus integer statistics.
    logic [W:0] m_q[$];
    int         m_res;
    int         m_zero;
    int         m_sum;
    bit         m_drop;

    typedef struct {
        logic       iv;
        logic [4:0] r;
        logic       zf;
        logic       ordy;
        int         e_level;
        logic       e_vld;
        int         e_r;
        logic       e_rdy;
        logic       e_drop;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit iv, input int r, input bit zf, input bit ordy);
        bit full;
        if (rst) begin
            m_q.delete();
            m_res  = 0;
            m_zero = 0;
            m_sum  = 0;
            m_drop = 0;
        end else begin
            full = (m_q.size() == DEPTH);
            if (iv && full) m_drop = 1;
            if (ordy && m_q.size() > 0) void'(m_q.pop_front());
            if (iv && !full) begin
                m_q.push_back({zf, r[W-1:0]});
                if (m_res < 255) m_res++;
                if (zf && m_zero < 255) m_zero++;
                m_sum = (m_sum + r) % 256;
            end
        end
    endtask

    task automatic check_all();
        chk("level", 32'(level), m_q.size());
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        chk("res_cnt", 32'(res_cnt), m_res);
        chk("zero_cnt", 32'(zero_cnt), m_zero);
        chk("r_sum", 32'(r_sum), m_sum);
        chk("drop", 32'(drop), 32'(m_drop));
        if (m_q.size() > 0) begin
            chk("out_r", 32'(out_r), 32'(m_q[0][W-1:0]));
            chk("out_zf", 32'(out_zf), 32'(m_q[0][W]));
        end
    endtask

    // Drive one cycle's inputs, clock, then compare against the model.
    task automatic cycle(input bit rst, input bit iv, input int r, input bit zf, input bit ordy);
        reset     = rst;
        in_valid  = iv;
        R         = r[W-1:0];
        ZF        = zf;
        out_ready = ordy;
        @(posedge clk);
        #1;
        model_step(rst, iv, r, zf, ordy);
        check_all();
    endtask

    task automatic do_reset();
        cycle(1, 1, 21, 1, 1);
        cycle(1, 0, 0, 0, 0);
        chk("rst_out_r", 32'(out_r), 0);
        chk("rst_out_zf", 32'(out_zf), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        R         = '0;
        ZF        = 1'b0;
        out_ready = 1'b0;
        m_q.delete();
        m_res = 0; m_zero = 0; m_sum = 0; m_drop = 0;

        //           iv  r  zf ordy lvl vld r  rdy drop
        tbl[0] = '{1'b1, 5'd1, 1'b0, 1'b0, 1, 1'b1, 1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd2, 1'b0, 1'b0, 2, 1'b1, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 5'd3, 1'b0, 1'b0, 3, 1'b1, 1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 5'd4, 1'b0, 1'b0, 4, 1'b1, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 5'd5, 1'b0, 1'b0, 4, 1'b1, 1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 1'b0, 1'b1, 3, 1'b1, 2, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 5'd0, 1'b0, 1'b1, 2, 1'b1, 3, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 1'b0, 1'b1, 1, 1'b1, 4, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1};

        // Single entry
        do_reset();
        cycle(0, 1, 9, 0, 0);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_r", 32'(out_r), 9);
        chk("t1_level", 32'(level), 1);
        chk("t1_res_cnt", 32'(res_cnt), 1);
        chk("t1_r_sum", 32'(r_sum), 9);
        chk("t1_zero_cnt", 32'(zero_cnt), 0);

        // Fill, overflow, drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, tbl[i].iv, int'(tbl[i].r), tbl[i].zf, tbl[i].ordy);
            chk($sformatf("t2_level[%0d]", i), 32'(level), tbl[i].e_level);
            chk($sformatf("t2_vld[%0d]", i), 32'(out_valid), 32'(tbl[i].e_vld));
            chk($sformatf("t2_rdy[%0d]", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("t2_drop[%0d]", i), 32'(drop), 32'(tbl[i].e_drop));
            if (tbl[i].e_vld) chk($sformatf("t2_out_r[%0d]", i), 32'(out_r), tbl[i].e_r);
            if (i == 4) begin
                chk("t2_res_cnt", 32'(res_cnt), 4);
                chk("t2_r_sum", 32'(r_sum), 10);
            end
        end

        // Streaming with consumer always ready
        do_reset();
        cycle(0, 1, 0, 1, 1);
        chk("t3_vld0", 32'(out_valid), 1);
        chk("t3_r0", 32'(out_r), 0);
        chk("t3_zf0", 32'(out_zf), 1);
        chk("t3_lvl0", 32'(level <= 1), 1);
        cycle(0, 1, 7, 0, 1);
        chk("t3_r1", 32'(out_r), 7);
        chk("t3_zf1", 32'(out_zf), 0);
        chk("t3_lvl1", 32'(level <= 1), 1);
        cycle(0, 0, 0, 0, 1);
        chk("t3_vld2", 32'(out_valid), 0);
        chk("t3_zero_cnt", 32'(zero_cnt), 1);
        chk("t3_r_sum", 32'(r_sum), 7);

        // Pointer wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 1, 31, 0, i > 0);
        cycle(0, 0, 0, 0, 1);
        chk("t4_empty", 32'(out_valid), 0);
        chk("t4_r_sum", 32'(r_sum), 54);
        chk("t4_res_cnt", 32'(res_cnt), 10);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) cycle(0, 1, 0, 1, 1);
        chk("t5_zero_cnt", 32'(zero_cnt), 255);
        chk("t5_res_cnt", 32'(res_cnt), 255);
        chk("t5_r_sum", 32'(r_sum), 0);

        // Reset mid-operation with drop already set
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 10 + i, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("t6_pre_level", 32'(level), 3);
        chk("t6_pre_drop", 32'(drop), 1);
        cycle(1, 1, 13, 0, 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_vld", 32'(out_valid), 0);
        chk("t6_rdy", 32'(in_ready), 1);
        chk("t6_drop", 32'(drop), 0);
        chk("t6_res_cnt", 32'(res_cnt), 0);
        chk("t6_zero_cnt", 32'(zero_cnt), 0);
        chk("t6_r_sum", 32'(r_sum), 0);
        cycle(0, 1, 17, 1, 0);
        chk("t6_first_r", 32'(out_r), 17);
        chk("t6_first_zf", 32'(out_zf), 1);
        chk("t6_first_lvl", 32'(level), 1);

        // Randomized traffic, including ZF inconsistent with R and sporadic resets
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 200) == 0, ($urandom % 4) != 0, int'($urandom % 32),
                  $urandom % 2, $urandom % 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream capture stage for the 5-bit ALU FSM: accepts each ALU result (R, ZF) with a valid/ready handshake and buffers it in a small FIFO.
- Presents results to a consumer (display, UART or checker) through a valid/ready output port.
- Keeps running statistics: accepted-result count, zero-flag count, wrapping sum of R, and a sticky drop flag.
- Lets the ALU FSM run back-to-back operations without stalling on a slow consumer.

Parameters:
- W, 5, result width; matches the ALU R bus.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_W, 8, width of the statistic counters and the sum accumulator.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result present this cycle.
- R  in  W  ALU result.
- ZF  in  1  ALU zero flag for R.
- in_ready  out  1  FIFO can accept an entry.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes the head entry.
- out_r  out  W  head result.
- out_zf  out  1  head zero flag.
- level  out  $clog2(DEPTH)+1  current occupancy.
- res_cnt  out  CNT_W  accepted results; saturating.
- zero_cnt  out  CNT_W  accepted results with ZF=1; saturating.
- r_sum  out  CNT_W  sum of accepted R values, modulo 2^CNT_W.
- drop  out  1  sticky; set when in_valid=1 while in_ready=0.

Behaviour:
- Reset, checked at a clock edge while reset=1:
  - read/write pointers = 0, level = 0, out_valid = 0, in_ready = 1.
  - res_cnt, zero_cnt, r_sum = 0; drop = 0.
  - out_r = 0 and out_zf = 0, because the head of cleared storage reads as 0.
  - Reset takes priority over a push or pop in the same cycle; entries in flight are discarded.
  - Storage contents are also cleared.
- Push: when in_valid && in_ready, {ZF,R} is written at wr_ptr and wr_ptr increments.
- Pop: when out_valid && out_ready, rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty: pointers equal.
  - full: MSBs differ and the low bits are equal.
- in_ready = !full. This is combinational from registered state and does not depend on out_ready, so there is no pop-to-push bypass when full.
- out_valid = !empty.
- out_r and out_zf come from the head entry combinationally and are stable while out_valid=1 && out_ready=0.
- Latency: an entry pushed at edge N is visible at the output (out_valid=1) after edge N; there is no same-cycle fall-through.
- level changes per cycle:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
  - Simultaneous push and pop is legal whenever 0 < level < DEPTH.
- Statistics update only on accepted pushes:
  - res_cnt +1 per push; holds at 2^CNT_W-1 (saturates).
  - zero_cnt +1 per push with ZF=1; saturates the same way.
  - r_sum += zero-extended R; wraps modulo 2^CNT_W.
- drop is set on any cycle with in_valid=1 && full. The entry is discarded and the statistics are not updated. drop clears only on reset.
- ZF is not recomputed; it is stored exactly as received, even if inconsistent with R.
- out_ready asserted while empty has no effect.

Decomposition:
- Package alu_pkg holds:
  - localparam ALU_W = 5.
  - typedef struct packed {logic zf; logic [ALU_W-1:0] r;} alu_res_t, used for FIFO entries.
  - Shared saturate-increment function sat_inc.
- One sub-module, alu_res_mem: DEPTH x alu_res_t register file with a synchronous write port and a combinational read port, cleared on reset.
- Pointer, flag and statistic logic lives in alu_result_fifo.

Test Plan:
1. Single entry: reset 2 cycles, push R=5'd9 ZF=0 with out_ready=0.
   - Next cycle: out_valid=1, out_r=9, level=1, res_cnt=1, r_sum=9, zero_cnt=0.
2. Fill and overflow: push R=1,2,3,4 with out_ready=0.
   - level=4, in_ready=0.
   - A 5th push of R=5 sets drop=1; res_cnt stays 4 and r_sum stays 10.
   - Draining gives 1,2,3,4 in order, then out_valid=0.
3. Streaming: out_ready=1 throughout, push R=0 ZF=1 then R=7 ZF=0 on consecutive cycles.
   - Outputs appear one cycle after each push.
   - level never exceeds 1; zero_cnt=1, r_sum=7.
4. Pointer wrap-around: 10 push/pop pairs with R=31 each.
   - FIFO order is preserved across the wrap.
   - r_sum = 310 mod 256 = 54.
5. Saturation: 300 pushes of ZF=1, R=0 with out_ready=1.
   - zero_cnt=255, res_cnt=255, r_sum=0.
6. Reset mid-operation: assert reset while level=3 and a push is in progress.
   - Next cycle: level=0, out_valid=0, in_ready=1, drop=0, all counters 0.
   - The next push after reset is the first result the consumer sees.
